// File: rtl/hb_filter_pkg.sv
// Shared halfband filter definitions: coefficients, data/accumulator formats, FSM and MAC types.
package hb_filter_pkg;

    localparam int unsigned DATA_W       = 18;  // 1s17 samples, 2s16 pre-adder sums, 0s18 taps
    localparam int unsigned ACC_W        = 36;  // 2s34 products and accumulator
    localparam int unsigned TAPS         = 7;
    localparam int unsigned CENTRE_SHIFT = 16;  // 1s17 -> 2s34 with the 0.5 centre tap folded in
    localparam int unsigned TRIM_LSB     = 17;  // 2s34 -> 1s17
    localparam int unsigned TRIM_MSB     = TRIM_LSB + DATA_W - 1;

    localparam logic signed [DATA_W-1:0] H1 = -18'sd9220;
    localparam logic signed [DATA_W-1:0] H3 = 18'sd74920;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC0,
        ST_MAC1,
        ST_OUT
    } hb_state_e;

    typedef enum logic [1:0] {
        MAC_HOLD,
        MAC_LOAD,
        MAC_ADD
    } mac_op_e;

    typedef struct packed {
        logic signed [DATA_W-1:0] pa1;
        logic signed [DATA_W-1:0] pa3;
        logic signed [ACC_W-1:0]  centre;
    } mac_operands_t;

endpackage

// File: rtl/hb_mac.sv
// Time-shared MAC: operand mux by operation, one 18x18 multiplier, 36-bit accumulator.
module hb_mac
    import hb_filter_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  mac_op_e                 op,
    input  mac_operands_t           opnd,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [DATA_W-1:0] coef_c;
    logic signed [DATA_W-1:0] data_c;
    logic signed [ACC_W-1:0]  prod_c;

    // Load pairs the outer tap with pa1, add pairs the inner tap with pa3
    always_comb begin
        coef_c = H1;
        data_c = $signed(opnd.pa1);
        if (op == MAC_ADD) begin
            coef_c = H3;
            data_c = $signed(opnd.pa3);
        end
        prod_c = ACC_W'(coef_c) * ACC_W'(data_c);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else begin
            case (op)
                MAC_LOAD: acc <= $signed(opnd.centre) + prod_c;
                MAC_ADD:  acc <= acc + prod_c;
                default:  acc <= acc;
            endcase
        end
    end

endmodule

// File: rtl/halfband_filter_decim.sv
// 7-tap halfband decimate-by-2 filter: delay line, pre-adders, MAC sequencer, output trim.
// Define HB_DECIM_SAT_EN to saturate y on accumulator overflow instead of wrapping.
module halfband_filter_decim
    import hb_filter_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sam_clk_en,
    input  logic                     sym_clk_en,
    input  logic signed [DATA_W-1:0] x_in,
    output logic signed [DATA_W-1:0] y,
    output logic                     y_valid
);

    logic [TAPS-1:0][DATA_W-1:0] x_q;
    logic                        strobe_c;
    mac_operands_t               opnd_c;
    mac_op_e                     mac_op_c;
    logic                        out_fire_c;
    hb_state_e                   state_q;
    hb_state_e                   state_d;
    logic signed [ACC_W-1:0]     acc;
    logic signed [DATA_W-1:0]    y_trim_c;
    logic                        unused_acc_c;

    assign strobe_c = sam_clk_en & sym_clk_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
        end else if (sam_clk_en) begin
            x_q <= {x_q[TAPS-2:0], x_in};
        end
    end

    // Symmetric taps share one multiply; halving first keeps the sums in 18 bits
    always_comb begin
        opnd_c.pa1    = ($signed(x_q[0]) >>> 1) + ($signed(x_q[6]) >>> 1);
        opnd_c.pa3    = ($signed(x_q[2]) >>> 1) + ($signed(x_q[4]) >>> 1);
        opnd_c.centre = ACC_W'($signed(x_q[3])) <<< CENTRE_SHIFT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A strobe always restarts the sequence, dropping any result still in flight
    always_comb begin
        state_d    = state_q;
        mac_op_c   = MAC_HOLD;
        out_fire_c = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_MAC0: begin
                mac_op_c = MAC_LOAD;
                state_d  = ST_MAC1;
            end
            ST_MAC1: begin
                mac_op_c = MAC_ADD;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                out_fire_c = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (strobe_c) begin
            state_d    = ST_MAC0;
            out_fire_c = 1'b0;
        end
    end

    hb_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .op    (mac_op_c),
        .opnd  (opnd_c),
        .acc   (acc)
    );

    always_comb begin
        y_trim_c = acc[TRIM_MSB:TRIM_LSB];
`ifdef HB_DECIM_SAT_EN
        if (acc[ACC_W-1] != acc[ACC_W-2]) begin
            y_trim_c = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
    end

    // Fraction bits below the output LSB are truncated by design
    assign unused_acc_c = ^{acc[ACC_W-1], acc[TRIM_LSB-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= out_fire_c;
            if (out_fire_c) begin
                y <= y_trim_c;
            end
        end
    end

endmodule

// File: tb/tb_halfband_filter_decim.sv
// Directed bench for halfband_filter_decim with a per-cycle filter-equation model.
module tb_halfband_filter_decim;

    localparam longint C_H1 = -9220;
    localparam longint C_H3 = 74920;

    logic               clk        = 1'b0;
    logic               reset      = 1'b1;
    logic               sam_clk_en = 1'b0;
    logic               sym_clk_en = 1'b0;
    logic signed [17:0] x_in       = '0;
    logic signed [17:0] y;
    logic               y_valid;

    always #5 clk = ~clk;

    halfband_filter_decim dut (
        .clk        (clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .x_in       (x_in),
        .y          (y),
        .y_valid    (y_valid)
    );

    typedef struct {
        int                 due;
        logic signed [17:0] val;
    } exp_t;

    int                 cyc = 0;
    exp_t               expq[$];
    longint             hist[7];
    logic signed [17:0] model_y = '0;
    logic signed [17:0] cap_y[$];
    int                 cap_cyc[$];
    int                 n_checks = 0;
    int                 n_pass = 0;
    int                 second_edge = 0;
    int                 exp_imp_strobe[5] = '{-2305, 18730, 18730, -2305, 0};
    int                 exp_imp_other[4]  = '{0, 32768, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    // Filter equation on the sample history: y = floor(sum(h*x) scaled to 1s17)
    function automatic logic signed [17:0] model_out();
        longint p1 = (hist[0] >>> 1) + (hist[6] >>> 1);
        longint p3 = (hist[2] >>> 1) + (hist[4] >>> 1);
        longint a  = hist[3] * 65536 + C_H1 * p1 + C_H3 * p3;
        longint q  = a >>> 17;
`ifdef HB_DECIM_SAT_EN
        if (q > 131071) q = 131071;
        if (q < -131072) q = -131072;
`endif
        return 18'(q);
    endfunction

    task automatic model_clear();
        expq.delete();
        foreach (hist[i]) hist[i] = 0;
        model_y = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a sample for the next clock edge; a strobe cancels any output not yet issued
    task automatic present(input longint x, input bit s);
        exp_t e;
        sam_clk_en = 1'b1;
        sym_clk_en = s;
        x_in       = 18'(x);
        for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
        if (s) begin
            while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
            e.due = cyc + 4;
            e.val = model_out();
            expq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            sam_clk_en = 1'b0;
            sym_clk_en = 1'b1;
            x_in       = 18'($urandom);
        end
    endtask

    task automatic send(input longint x, input bit s);
        present(x, s);
        idle(4);
    endtask

    task automatic cap_clear();
        cap_y.delete();
        cap_cyc.delete();
    endtask

    always @(negedge clk) begin
        bit ev;
        if (!reset) begin
            check("reset_y", y, 0);
            check("reset_y_valid", y_valid, 0);
        end else begin
            ev = (expq.size() > 0) && (expq[0].due == cyc);
            if (ev) begin
                model_y = expq[0].val;
                void'(expq.pop_front());
            end
            check("y_valid", y_valid, ev);
            check("y", y, model_y);
            if (y_valid) begin
                cap_y.push_back(y);
                cap_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        model_clear();
        #1 reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        idle(2);

        // Constant +0.5: DC gain slightly above one, one output per 8 clk
        cap_clear();
        repeat (6) begin send(65536, 1); send(65536, 0); end
        idle(4);
        check("const_pos_count", cap_y.size(), 6);
        if (cap_y.size() >= 2) begin
            check("const_pos_y", cap_y[cap_y.size()-1], 65618);
            check("const_pos_period", cap_cyc[cap_cyc.size()-1] - cap_cyc[cap_cyc.size()-2], 8);
        end

        // Reset in the middle of a computation, then resume on the next strobe
        present(65536, 1);
        idle(2);
        reset = 1'b0;
        model_clear();
        idle(5);
        reset = 1'b1;
        cap_clear();
        send(0, 0);
        send(65536, 1);
        idle(4);
        check("post_reset_count", cap_y.size(), 1);
        if (cap_y.size() >= 1) check("post_reset_y", cap_y[0], -2305);

        // Impulse landing on a strobe sample
        repeat (4) begin send(0, 1); send(0, 0); end
        idle(4);
        cap_clear();
        send(65536, 1);
        send(0, 0);
        repeat (4) begin send(0, 1); send(0, 0); end
        idle(4);
        check("imp_strobe_count", cap_y.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < cap_y.size()) check($sformatf("imp_strobe_y%0d", i), cap_y[i], exp_imp_strobe[i]);

        // Impulse landing on a non-strobe sample
        repeat (4) begin send(0, 1); send(0, 0); end
        idle(4);
        cap_clear();
        send(65536, 0);
        repeat (4) begin send(0, 1); send(0, 0); end
        idle(4);
        check("imp_other_count", cap_y.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < cap_y.size()) check($sformatf("imp_other_y%0d", i), cap_y[i], exp_imp_other[i]);

        // Full-scale negative input overflows the output format
        cap_clear();
        repeat (6) begin send(-131072, 1); send(-131072, 0); end
        idle(4);
        check("const_neg_count", cap_y.size(), 6);
        if (cap_y.size() >= 1) begin
`ifdef HB_DECIM_SAT_EN
            check("const_neg_y", cap_y[cap_y.size()-1], -131072);
`else
            check("const_neg_y", cap_y[cap_y.size()-1], 130908);
`endif
        end

        // Second strobe arrives while the first is in MAC1
        cap_clear();
        present(1000, 1);
        idle(2);
        present(2000, 1);
        second_edge = cyc + 1;
        idle(6);
        check("restart_count", cap_y.size(), 1);
        if (cap_cyc.size() >= 1) check("restart_latency", cap_cyc[0] - second_edge, 3);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
